tb_mem_regbus_multi: RTL and testbench
======================================

TB_MEM_REGBUS_MULTI -- requirements
Module: tb_mem_regbus_multi

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of independent regbus requester ports, 1..8.
REQ-002 SHALL have parameter AddrWidth, default 48: regbus address width per port.
REQ-003 SHALL have parameter DataWidth, default 32: data width, 32 or 64.
REQ-004 SHALL have parameter Depth, default 1024: memory words; power of two.
REQ-005 SHALL have parameter BaseAddr, default 0: byte address of word 0; aligned to Depth*DataWidth/8.
REQ-006 SHALL have parameter Latency, default 0: extra wait cycles per access, 0..15.
REQ-007 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-008 rst_i  in  1  reset; synchronous, active-high.
REQ-009 valid_i  in  NumPorts  per-port request valid.
REQ-010 write_i  in  NumPorts  per-port 1=write, 0=read.
REQ-011 addr_i  in  NumPorts*AddrWidth  per-port byte address, port p at slice p.
REQ-012 wdata_i  in  NumPorts*DataWidth  per-port write data.
REQ-013 wstrb_i  in  NumPorts*DataWidth/8  per-port byte enables.
REQ-014 ready_o  out  NumPorts  per-port one-cycle completion strobe.
REQ-015 rdata_o  out  NumPorts*DataWidth  per-port read data, valid when ready_o bit set.
REQ-016 error_o  out  NumPorts  per-port error, valid when ready_o bit set.
REQ-017 access_cnt_o  out  32  completed accesses, saturating.
REQ-018 error_cnt_o  out  32  completed error accesses, saturating.

Function
REQ-019 Requester SHALL hold valid/write/addr/wdata/wstrb stable from valid rise until its ready_o pulse.
REQ-020 FSM states: IDLE, WAIT, RESP; one access in flight at a time.
REQ-021 IDLE: if any valid_i set, grant one port by round-robin and go WAIT with counter=Latency; otherwise stay IDLE.
REQ-022 Round-robin: search starts at port (last_grant+1) mod NumPorts; last_grant=NumPorts-1 after reset, so port 0 wins first.
REQ-023 WAIT: counter>0 decrements; counter==0 -> RESP.
REQ-024 RESP: ready_o[grant]=1 for exactly this cycle, access performed, then IDLE; last_grant updated.
REQ-025 Latency: grant in cycle G -> ready_o in cycle G+1+Latency; next grant no earlier than the cycle after RESP.
REQ-026 Word index = (addr - BaseAddr) >> log2(DataWidth/8); low address bits ignored.
REQ-027 addr < BaseAddr or index >= Depth -> error_o=1, rdata_o=0, no write.
REQ-028 In-range write: bytes with wstrb bit set updated at RESP edge; others unchanged; rdata_o=0, error_o=0.
REQ-029 In-range read: rdata_o = word content at RESP, error_o=0.
REQ-030 Non-granted ports: ready_o=0, rdata_o=0, error_o=0 every cycle.
REQ-031 Granted valid_i dropping during WAIT/RESP (protocol violation) SHALL abort: no write, no ready, no count, return to IDLE next cycle.
REQ-032 access_cnt_o +1 per RESP; error_cnt_o +1 per RESP with error; both saturate at 0xFFFFFFFF.
REQ-033 Write of wstrb=0 SHALL complete normally and count as access, memory unchanged.

Reset
REQ-034 rst_i=1 at a clock edge -> FSM=IDLE, last_grant=NumPorts-1, counter=0, both counters=0, all ready_o/error_o/rdata_o=0 next cycle.
REQ-035 Reset mid-access (WAIT or RESP) SHALL cancel it: no write, no ready pulse.
REQ-036 Memory contents SHALL NOT be altered by reset.

Verification
REQ-037 Latency=0, port0 write addr=0x10 data=0xDEADBEEF wstrb=0xF, then read 0x10 -> ready at G+1 each, rdata=0xDEADBEEF, error=0, access_cnt=2.
REQ-038 Latency=3, port1 read -> ready_o[1] exactly at G+4, single-cycle pulse.
REQ-039 Ports 0,1 valid continuously with reads -> grants alternate 0,1,0,1; neither starves.
REQ-040 Write 0x11223344 then wstrb=0x2 data=0xAABBCCDD, read -> 0x1122CC44.
REQ-041 Read addr=BaseAddr+Depth*4 -> error_o=1, rdata=0, error_cnt=1, memory unchanged.
REQ-042 rst_i pulsed during WAIT of a write -> no ready pulse, location keeps old value, counters=0.

Source files
------------

// File: rtl/tb_mem_regbus_multi_if.sv
// Multi-port regbus bundle: per-port request fields in, per-port completion
// strobe, read data and error out. Port p occupies slice p of every vector.
interface tb_mem_regbus_multi_if #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 48,
    parameter int DataWidth = 32
);
    logic [NumPorts-1:0]             valid_i;
    logic [NumPorts-1:0]             write_i;
    logic [NumPorts*AddrWidth-1:0]   addr_i;
    logic [NumPorts*DataWidth-1:0]   wdata_i;
    logic [NumPorts*DataWidth/8-1:0] wstrb_i;
    logic [NumPorts-1:0]             ready_o;
    logic [NumPorts*DataWidth-1:0]   rdata_o;
    logic [NumPorts-1:0]             error_o;

    modport master (
        output valid_i, write_i, addr_i, wdata_i, wstrb_i,
        input  ready_o, rdata_o, error_o
    );

    modport slave (
        input  valid_i, write_i, addr_i, wdata_i, wstrb_i,
        output ready_o, rdata_o, error_o
    );
endinterface

// File: rtl/tb_mem_regbus_multi.sv
// Word-addressed memory shared by NumPorts regbus requesters through a
// round-robin arbiter; one access in flight, optional extra wait cycles.
module tb_mem_regbus_multi #(
    parameter int          NumPorts  = 2,
    parameter int          AddrWidth = 48,
    parameter int          DataWidth = 32,
    parameter int          Depth     = 1024,
    parameter logic [63:0] BaseAddr  = 64'h0,
    parameter int          Latency   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tb_mem_regbus_multi_if.slave bus,
    output logic [31:0]          access_cnt_o,
    output logic [31:0]          error_cnt_o
);
    localparam int NumBytes  = DataWidth / 8;
    localparam int ByteShift = $clog2(NumBytes);
    localparam int IdxW      = $clog2(Depth);
    localparam int GrantW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [AddrWidth-1:0] BaseA  = BaseAddr[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(Depth);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [GrantW-1:0]   r_grant;
    logic [GrantW-1:0]   r_last_grant;
    logic [3:0]          r_cnt;
    logic [31:0]         r_access_cnt;
    logic [31:0]         r_error_cnt;

    logic [GrantW-1:0]   w_rr_pick;
    logic                w_rr_found;
    logic                w_any_valid;
    logic                w_hold;
    logic                w_fire;
    logic                w_write;
    logic [AddrWidth-1:0] w_addr;
    logic [AddrWidth-1:0] w_offset;
    logic [AddrWidth-1:0] w_word;
    logic [IdxW-1:0]     w_idx;
    logic                w_err;
    logic [DataWidth-1:0] w_wdata;
    logic [NumBytes-1:0] w_wstrb;
    logic [DataWidth-1:0] w_rd_word;
    logic                w_wr_en;

    // Fields of the granted port; the requester keeps them stable until ready.
    assign w_hold   = bus.valid_i[r_grant];
    assign w_write  = bus.write_i[r_grant];
    assign w_addr   = bus.addr_i[int'(r_grant)*AddrWidth +: AddrWidth];
    assign w_wdata  = bus.wdata_i[int'(r_grant)*DataWidth +: DataWidth];
    assign w_wstrb  = bus.wstrb_i[int'(r_grant)*NumBytes +: NumBytes];

    assign w_offset = w_addr - BaseA;
    assign w_word   = w_offset >> ByteShift;
    assign w_idx    = w_word[IdxW-1:0];
    assign w_err    = (w_addr < BaseA) || (w_word >= DepthA);

    // A granted requester that drops valid in RESP loses its completion.
    assign w_fire   = (r_state == S_RESP) && w_hold;
    assign w_wr_en  = !rst_i && w_fire && w_write && !w_err;

    assign w_any_valid  = |bus.valid_i;
    assign access_cnt_o = r_access_cnt;
    assign error_cnt_o  = r_error_cnt;

    always_comb begin
        w_rr_pick  = r_last_grant;
        w_rr_found = 1'b0;
        for (int k = 1; k <= NumPorts; k++) begin
            if (!w_rr_found && bus.valid_i[(int'(r_last_grant) + k) % NumPorts]) begin
                w_rr_pick  = GrantW'((int'(r_last_grant) + k) % NumPorts);
                w_rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GrantW'(NumPorts - 1);
            r_cnt        <= '0;
            r_access_cnt <= '0;
            r_error_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant <= w_rr_pick;
                        r_cnt   <= 4'(Latency);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_hold) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (w_hold) begin
                        r_last_grant <= r_grant;
                        if (r_access_cnt != 32'hFFFF_FFFF) begin
                            r_access_cnt <= r_access_cnt + 32'd1;
                        end
                        if (w_err && r_error_cnt != 32'hFFFF_FFFF) begin
                            r_error_cnt <= r_error_cnt + 32'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    genvar gi;

    // One byte-wide RAM per lane; the read is taken every cycle so the word
    // addressed during the last WAIT cycle is on r_rd throughout RESP.
    for (gi = 0; gi < NumBytes; gi++) begin : g_lane
        logic [7:0] r_mem [Depth];
        logic [7:0] r_rd;

        always_ff @(posedge clk_i) begin
            r_rd <= r_mem[w_idx];
            if (w_wr_en && w_wstrb[gi]) begin
                r_mem[w_idx] <= w_wdata[gi*8 +: 8];
            end
        end

        assign w_rd_word[gi*8 +: 8] = r_rd;
    end

    for (gi = 0; gi < NumPorts; gi++) begin : g_port
        logic w_sel;

        assign w_sel = w_fire && (r_grant == GrantW'(gi));
        assign bus.ready_o[gi] = w_sel;
        assign bus.error_o[gi] = w_sel && w_err;
        assign bus.rdata_o[gi*DataWidth +: DataWidth] =
            (w_sel && !w_write && !w_err) ? w_rd_word : '0;
    end
endmodule

// File: tb/tb_tb_mem_regbus_multi.sv
// Randomised self-checking bench: two instances (no extra latency at base 0,
// three wait cycles at base 0x4000) checked against a word-array model.
module tb_tb_mem_regbus_multi;
    localparam int NP   = 2;
    localparam int AW   = 48;
    localparam int DW   = 32;
    localparam int DEP  = 256;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic [31:0] acc0, err0, acc3, err3;

    tb_mem_regbus_multi_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus0 ();
    tb_mem_regbus_multi_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus3 ();

    tb_mem_regbus_multi #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .Depth(DEP),
        .BaseAddr(64'h0), .Latency(0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .bus(bus0),
        .access_cnt_o(acc0), .error_cnt_o(err0)
    );

    tb_mem_regbus_multi #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .Depth(DEP),
        .BaseAddr(64'h4000), .Latency(LAT3)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .bus(bus3),
        .access_cnt_o(acc3), .error_cnt_o(err3)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [2][DEP];
    int          exp_acc [2];
    int          exp_err [2];
    int          last_port [2];

    function automatic logic [47:0] base_of(input int d);
        return (d == 0) ? 48'h0 : 48'h4000;
    endfunction

    // From an idle memory, valid seen in cycle V: grant visible in V+1,
    // ready in V+2+Latency.
    function automatic int exp_lat(input int d);
        return ((d == 0) ? 0 : LAT3) + 2;
    endfunction

    function automatic bit in_range(input int d, input logic [47:0] a);
        if (a < base_of(d)) return 1'b0;
        return ((a - base_of(d)) / 4) < DEP;
    endfunction

    function automatic int widx(input int d, input logic [47:0] a);
        return int'((a - base_of(d)) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (ws[b]) res[b*8 +: 8] = wd[b*8 +: 8];
        return res;
    endfunction

    task automatic set_req(input int d, input int p, input bit v, input bit wr,
                           input logic [47:0] a, input logic [31:0] wd, input logic [3:0] ws);
        if (d == 0) begin
            bus0.valid_i[p] = v; bus0.write_i[p] = wr;
            bus0.addr_i[p*AW +: AW] = a; bus0.wdata_i[p*DW +: DW] = wd;
            bus0.wstrb_i[p*4 +: 4] = ws;
        end else begin
            bus3.valid_i[p] = v; bus3.write_i[p] = wr;
            bus3.addr_i[p*AW +: AW] = a; bus3.wdata_i[p*DW +: DW] = wd;
            bus3.wstrb_i[p*4 +: 4] = ws;
        end
    endtask

    function automatic logic [1:0] rdy(input int d);
        return (d == 0) ? bus0.ready_o : bus3.ready_o;
    endfunction

    function automatic logic [1:0] errv(input int d);
        return (d == 0) ? bus0.error_o : bus3.error_o;
    endfunction

    function automatic logic [31:0] rdat(input int d, input int p);
        return (d == 0) ? bus0.rdata_o[p*DW +: DW] : bus3.rdata_o[p*DW +: DW];
    endfunction

    // One complete transaction on one port; also advances the model.
    task automatic do_access(input int d, input int p, input bit wr, input logic [47:0] a,
                             input logic [31:0] wd, input logic [3:0] ws,
                             output int lat, output logic [31:0] rd, output logic er,
                             output logic after, output logic oth_rdy, output logic [31:0] oth_rd);
        logic [1:0] r;
        logic [1:0] e;
        bit         got;
        got = 0; lat = 0; rd = '0; er = 1'b0; after = 1'b0; oth_rdy = 1'b0; oth_rd = '0;
        set_req(d, p, 1'b1, wr, a, wd, ws);
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            r = rdy(d);
            if (r[p]) begin
                got = 1; lat = c; rd = rdat(d, p);
                e = errv(d); er = e[p];
                oth_rdy = r[1-p]; oth_rd = rdat(d, 1-p);
            end
        end
        if (got) begin
            @(posedge clk); #1;
            r = rdy(d);
            after = r[p];
            exp_acc[d]++;
            last_port[d] = p;
            if (!in_range(d, a)) exp_err[d]++;
            else if (wr) mem_m[d][widx(d, a)] = merge(mem_m[d][widx(d, a)], wd, ws);
        end
        set_req(d, p, 1'b0, 1'b0, '0, '0, '0);
        $display("txn dut%0d port%0d %s addr=%h wdata=%h wstrb=%h lat=%0d rdata=%h err=%0d",
                 d, p, wr ? "WR" : "RD", a, wd, ws, lat, rd, er);
    endtask

    task automatic test_reset();
        if (bus0.ready_o !== 2'b00 || bus3.ready_o !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b/%b expected 00", bus0.ready_o, bus3.ready_o);
        end
        checks++;
        if (bus0.error_o !== 2'b00 || bus3.error_o !== 2'b00) begin
            errors++; $display("FAIL reset_error: got %b/%b expected 00", bus0.error_o, bus3.error_o);
        end
        checks++;
        if (bus0.rdata_o !== 64'h0 || bus3.rdata_o !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0", bus0.rdata_o, bus3.rdata_o);
        end
        checks++;
        if (acc0 !== 32'd0 || acc3 !== 32'd0) begin
            errors++; $display("FAIL reset_access_cnt: got %0d/%0d expected 0", acc0, acc3);
        end
        checks++;
        if (err0 !== 32'd0 || err3 !== 32'd0) begin
            errors++; $display("FAIL reset_error_cnt: got %0d/%0d expected 0", err0, err3);
        end
        checks++;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord;
        do_access(0, 0, 1'b1, 48'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er, af, orr, ord);
        checks++;
        if (lat !== exp_lat(0) || rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL basic_write: lat=%0d rdata=%h err=%0d expected lat=%0d rdata=0 err=0",
                               lat, rd, er, exp_lat(0));
        end
        do_access(0, 0, 1'b0, 48'h10, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (lat !== exp_lat(0) || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++; $display("FAIL basic_read: lat=%0d rdata=%h err=%0d expected lat=%0d rdata=deadbeef err=0",
                               lat, rd, er, exp_lat(0));
        end
        checks++;
        if (acc0 !== 32'd2) begin
            errors++; $display("FAIL basic_access_cnt: got %0d expected 2", acc0);
        end
    endtask

    task automatic test_strobe();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord;
        do_access(0, 1, 1'b1, 48'h20, 32'h1122_3344, 4'hF, lat, rd, er, af, orr, ord);
        do_access(0, 1, 1'b1, 48'h22, 32'hAABB_CCDD, 4'h2, lat, rd, er, af, orr, ord);
        do_access(0, 1, 1'b0, 48'h20, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (rd !== 32'h1122_CC44) begin
            errors++; $display("FAIL strobe_merge: got %h expected 1122cc44", rd);
        end
        do_access(0, 0, 1'b1, 48'h20, 32'hFFFF_FFFF, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (acc0 !== 32'(exp_acc[0]) || er !== 1'b0) begin
            errors++; $display("FAIL strobe_zero_count: cnt=%0d err=%0d expected cnt=%0d err=0",
                               acc0, er, exp_acc[0]);
        end
        do_access(0, 0, 1'b0, 48'h20, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (rd !== mem_m[0][8]) begin
            errors++; $display("FAIL strobe_zero_unchanged: got %h expected %h", rd, mem_m[0][8]);
        end
    endtask

    task automatic test_error();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord;
        do_access(0, 0, 1'b0, 48'h400, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== exp_lat(0)) begin
            errors++; $display("FAIL oob_read: err=%0d rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d",
                               er, rd, lat, exp_lat(0));
        end
        checks++;
        if (err0 !== 32'(exp_err[0])) begin
            errors++; $display("FAIL oob_error_cnt: got %0d expected %0d", err0, exp_err[0]);
        end
        do_access(0, 1, 1'b1, 48'h420, 32'h0BAD_0BAD, 4'hF, lat, rd, er, af, orr, ord);
        do_access(0, 1, 1'b0, 48'h20, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (rd !== mem_m[0][8] || err0 !== 32'(exp_err[0])) begin
            errors++; $display("FAIL oob_write_no_alias: rdata=%h errcnt=%0d expected rdata=%h errcnt=%0d",
                               rd, err0, mem_m[0][8], exp_err[0]);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord;
        logic [31:0] erd; logic eer; int p; bit wr; logic [47:0] a; int k;
        logic [31:0] wd; logic [3:0] ws;
        for (int w = 0; w < 16; w++) begin
            do_access(0, w % 2, 1'b1, 48'(w * 4), $urandom, 4'hF, lat, rd, er, af, orr, ord);
        end
        for (int n = 0; n < 50; n++) begin
            p = int'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 7));
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            if (k == 0)      a = 48'h400 + 48'($urandom_range(0, 1023));
            else if (k == 1) a = 48'hFFFF_0000_0000 | 48'($urandom);
            else             a = 48'($urandom_range(0, 15)) * 4 + 48'($urandom_range(0, 3));
            eer = !in_range(0, a);
            erd = (!wr && !eer) ? mem_m[0][widx(0, a)] : 32'h0;
            do_access(0, p, wr, a, wd, ws, lat, rd, er, af, orr, ord);
            checks++;
            if (lat !== exp_lat(0) || rd !== erd || er !== eer || af !== 1'b0) begin
                errors++; $display("FAIL rand_%0d: lat=%0d rdata=%h err=%0d after=%0d expected lat=%0d rdata=%h err=%0d after=0",
                                   n, lat, rd, er, af, exp_lat(0), erd, eer);
            end
            checks++;
            if (orr !== 1'b0 || ord !== 32'h0) begin
                errors++; $display("FAIL rand_other_%0d: ready=%0d rdata=%h expected 0/0", n, orr, ord);
            end
        end
        checks++;
        if (acc0 !== 32'(exp_acc[0]) || err0 !== 32'(exp_err[0])) begin
            errors++; $display("FAIL rand_counters: acc=%0d err=%0d expected acc=%0d err=%0d",
                               acc0, err0, exp_acc[0], exp_err[0]);
        end
    endtask

    task automatic test_round_robin();
        int exp_p, n, prev; logic [1:0] r; logic [31:0] rd;
        exp_p = (last_port[0] + 1) % 2; n = 0; prev = -1;
        set_req(0, 0, 1'b1, 1'b0, 48'h0, 32'h0, 4'h0);
        set_req(0, 1, 1'b1, 1'b0, 48'h4, 32'h0, 4'h0);
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(posedge clk); #1;
            r = bus0.ready_o;
            if (r != 2'b00) begin
                rd = rdat(0, exp_p);
                checks++;
                if (r !== (2'b01 << exp_p) || rd !== mem_m[0][exp_p]) begin
                    errors++; $display("FAIL rr_grant_%0d: ready=%b rdata=%h expected ready=%b rdata=%h",
                                       n, r, rd, 2'b01 << exp_p, mem_m[0][exp_p]);
                end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 3) begin
                        errors++; $display("FAIL rr_spacing_%0d: got %0d cycles expected 3", n, c - prev);
                    end
                end
                $display("txn dut0 rr port%0d rdata=%h", exp_p, rd);
                last_port[0] = exp_p; exp_acc[0]++;
                exp_p = 1 - exp_p; prev = c; n++;
            end
        end
        checks++;
        if (n < 6) begin
            errors++; $display("FAIL rr_timeout: got %0d grants expected 6", n);
        end
        @(posedge clk); #1;
        set_req(0, 0, 1'b0, 1'b0, '0, '0, '0);
        set_req(0, 1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (acc0 !== 32'(exp_acc[0])) begin
            errors++; $display("FAIL rr_access_cnt: got %0d expected %0d", acc0, exp_acc[0]);
        end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord;
        do_access(1, 1, 1'b1, 48'h4018, $urandom, 4'hF, lat, rd, er, af, orr, ord);
        do_access(1, 0, 1'b1, 48'h4014, $urandom, 4'hF, lat, rd, er, af, orr, ord);
        do_access(1, 1, 1'b0, 48'h4018, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (lat !== exp_lat(1) || af !== 1'b0 || orr !== 1'b0) begin
            errors++; $display("FAIL lat3_timing: lat=%0d after=%0d other=%0d expected lat=%0d after=0 other=0",
                               lat, af, orr, exp_lat(1));
        end
        checks++;
        if (rd !== mem_m[1][6] || er !== 1'b0) begin
            errors++; $display("FAIL lat3_read: rdata=%h err=%0d expected rdata=%h err=0", rd, er, mem_m[1][6]);
        end
        do_access(1, 0, 1'b0, 48'h3FFC, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== exp_lat(1)) begin
            errors++; $display("FAIL below_base: err=%0d rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d",
                               er, rd, lat, exp_lat(1));
        end
        checks++;
        if (acc3 !== 32'(exp_acc[1]) || err3 !== 32'(exp_err[1])) begin
            errors++; $display("FAIL lat3_counters: acc=%0d err=%0d expected acc=%0d err=%0d",
                               acc3, err3, exp_acc[1], exp_err[1]);
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord; bit seen;
        set_req(1, 0, 1'b1, 1'b1, 48'h4014, 32'h5555_AAAA, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        set_req(1, 0, 1'b0, 1'b0, '0, '0, '0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus3.ready_o != 2'b00) seen = 1;
        end
        checks++;
        if (seen !== 1'b0 || acc3 !== 32'(exp_acc[1])) begin
            errors++; $display("FAIL abort_no_ready: seen=%0d acc=%0d expected seen=0 acc=%0d",
                               seen, acc3, exp_acc[1]);
        end
        do_access(1, 1, 1'b0, 48'h4014, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (rd !== mem_m[1][5]) begin
            errors++; $display("FAIL abort_no_write: got %h expected %h", rd, mem_m[1][5]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er, af, orr; logic [31:0] ord; bit seen;
        set_req(1, 1, 1'b1, 1'b1, 48'h4018, 32'h0123_4567, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        set_req(1, 1, 1'b0, 1'b0, '0, '0, '0);
        exp_acc[1] = 0; exp_err[1] = 0; last_port[1] = 1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus3.ready_o != 2'b00) seen = 1;
        end
        checks++;
        if (seen !== 1'b0 || acc3 !== 32'(exp_acc[1]) || err3 !== 32'(exp_err[1])) begin
            errors++; $display("FAIL rst_mid_cancel: seen=%0d acc=%0d err=%0d expected 0/0/0", seen, acc3, err3);
        end
        do_access(1, 1, 1'b0, 48'h4018, 32'h0, 4'h0, lat, rd, er, af, orr, ord);
        checks++;
        if (rd !== mem_m[1][6] || acc3 !== 32'(exp_acc[1])) begin
            errors++; $display("FAIL rst_mid_keep: rdata=%h acc=%0d expected rdata=%h acc=%0d",
                               rd, acc3, mem_m[1][6], exp_acc[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.valid_i = '0; bus0.write_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.wstrb_i = '0;
        bus3.valid_i = '0; bus3.write_i = '0; bus3.addr_i = '0; bus3.wdata_i = '0; bus3.wstrb_i = '0;
        for (int d = 0; d < 2; d++) begin
            exp_acc[d] = 0; exp_err[d] = 0; last_port[d] = NP - 1;
        end
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;

        test_reset();
        test_basic();
        test_strobe();
        test_error();
        test_random();
        test_round_robin();
        test_latency();
        test_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
